// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: round-robin arbiter between the CPU MEM stage and the
// debug/bridge port for the shared data memory. One DM command per cycle,
// grant is combinational, and load data is routed back to the issuing
// requester through an RD_LAT-deep {valid, owner} tag pipeline.
// Optional grant/conflict statistics are built when DM_ARB_STATS_EN is defined.
module dm_port_arbiter #(
  parameter int ADDR_W = 12,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [3:0]        cpu_byteen,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [31:0]       cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [31:0]       dbg_addr,
  input  logic [3:0]        dbg_byteen,
  input  logic [31:0]       dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [31:0]       dbg_rdata,
  output logic              dm_en,
  output logic [3:0]        dm_byteen,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  input  logic [31:0]       dm_rdata
`ifdef DM_ARB_STATS_EN
  ,
  output logic [15:0]       cpu_gnt_cnt,
  output logic [15:0]       dbg_gnt_cnt,
  output logic [15:0]       conflict_cnt
`endif
);

  // 0 = CPU was granted last, 1 = debug was granted last
  logic              last_gnt_reg;
  logic [RD_LAT-1:0] tag_valid_reg;
  logic [RD_LAT-1:0] tag_owner_reg;
  logic [RD_LAT-1:0] tag_valid_next;
  logic [RD_LAT-1:0] tag_owner_next;
  logic              issue_load;
  logic              ret_valid;
  logic              ret_owner;

  // Byte-offset bits and bits above the DM word range are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{cpu_addr[1:0], cpu_addr[31:ADDR_W+2],
                              dbg_addr[1:0], dbg_addr[31:ADDR_W+2]};

  // A lone requester always wins; on a tie the one not granted last wins.
  // Nothing is granted while reset is held.
  assign cpu_gnt = !reset && cpu_req && (!dbg_req || last_gnt_reg);
  assign dbg_gnt = !reset && dbg_req && (!cpu_req || !last_gnt_reg);

  // Drive the DM command from the granted requester, all zero when idle
  always_comb begin
    dm_en     = 1'b0;
    dm_byteen = 4'b0000;
    dm_addr   = '0;
    dm_wdata  = 32'h0;
    if (cpu_gnt) begin
      dm_en     = 1'b1;
      dm_byteen = cpu_we ? cpu_byteen : 4'b0000;
      dm_addr   = cpu_addr[ADDR_W+1:2];
      dm_wdata  = cpu_wdata;
    end else if (dbg_gnt) begin
      dm_en     = 1'b1;
      dm_byteen = dbg_we ? dbg_byteen : 4'b0000;
      dm_addr   = dbg_addr[ADDR_W+1:2];
      dm_wdata  = dbg_wdata;
    end
  end

  // Round-robin pointer moves only on cycles that actually grant
  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt_reg <= 1'b1;
    end else if (cpu_gnt || dbg_gnt) begin
      last_gnt_reg <= dbg_gnt;
    end
  end

  // Only loads enter the tag pipeline; zero-byteen stores are still stores.
  assign issue_load = (cpu_gnt && !cpu_we) || (dbg_gnt && !dbg_we);

  generate
    for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_tag
      if (gi == 0) begin : g_head
        assign tag_valid_next[gi] = issue_load;
        assign tag_owner_next[gi] = dbg_gnt;
      end else begin : g_tail
        assign tag_valid_next[gi] = tag_valid_reg[gi-1];
        assign tag_owner_next[gi] = tag_owner_reg[gi-1];
      end
    end
  endgenerate

  // Shift the {valid, owner} tags one stage per cycle; reset drops in-flight loads
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_valid_reg <= '0;
      tag_owner_reg <= '0;
    end else begin
      tag_valid_reg <= tag_valid_next;
      tag_owner_reg <= tag_owner_next;
    end
  end

  // The last tag stage lines up with dm_rdata for the load issued RD_LAT cycles ago.
  assign ret_valid  = tag_valid_reg[RD_LAT-1];
  assign ret_owner  = tag_owner_reg[RD_LAT-1];
  assign cpu_rvalid = ret_valid && !ret_owner;
  assign dbg_rvalid = ret_valid && ret_owner;
  assign cpu_rdata  = cpu_rvalid ? dm_rdata : 32'h0;
  assign dbg_rdata  = dbg_rvalid ? dm_rdata : 32'h0;

`ifdef DM_ARB_STATS_EN
  // Saturating grant and conflict counters
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_gnt_cnt  <= 16'h0;
      dbg_gnt_cnt  <= 16'h0;
      conflict_cnt <= 16'h0;
    end else begin
      if (cpu_gnt && cpu_gnt_cnt != 16'hFFFF) cpu_gnt_cnt <= cpu_gnt_cnt + 16'h1;
      if (dbg_gnt && dbg_gnt_cnt != 16'hFFFF) dbg_gnt_cnt <= dbg_gnt_cnt + 16'h1;
      if (cpu_req && dbg_req && conflict_cnt != 16'hFFFF) conflict_cnt <= conflict_cnt + 16'h1;
    end
  end
`endif

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed self-checking bench for dm_port_arbiter (RD_LAT=3, ADDR_W=12)
// with a byte-writable DM model whose read data follows the command by RD_LAT.
module tb_dm_port_arbiter;
  localparam int AW = 12;
  localparam int RL = 3;

  logic          clk;
  logic          reset;
  logic          cpu_req, cpu_we, dbg_req, dbg_we;
  logic [31:0]   cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic [3:0]    cpu_byteen, dbg_byteen;
  logic          cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
  logic [31:0]   cpu_rdata, dbg_rdata;
  logic          dm_en;
  logic [3:0]    dm_byteen;
  logic [AW-1:0] dm_addr;
  logic [31:0]   dm_wdata, dm_rdata;
`ifdef DM_ARB_STATS_EN
  logic [15:0]   cpu_gnt_cnt, dbg_gnt_cnt, conflict_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic addr_mode;

  dm_port_arbiter #(.ADDR_W(AW), .RD_LAT(RL)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_byteen(cpu_byteen), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_byteen(dbg_byteen), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .dm_en(dm_en), .dm_byteen(dm_byteen), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
`ifdef DM_ARB_STATS_EN
    , .cpu_gnt_cnt(cpu_gnt_cnt), .dbg_gnt_cnt(dbg_gnt_cnt), .conflict_cnt(conflict_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DM model: byte writes, read data captured at the command and delayed RL cycles
  logic [31:0] mem [0:(1<<AW)-1];
  logic [31:0] rd_pipe [RL];
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (dm_en && dm_byteen[b]) mem[dm_addr][b*8 +: 8] <= dm_wdata[b*8 +: 8];
    rd_pipe[0] <= (dm_en && dm_byteen == 4'b0000) ?
                  (addr_mode ? {20'h0, dm_addr} : mem[dm_addr]) : 32'h0;
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign dm_rdata = rd_pipe[RL-1];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s = %0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_cpu(input logic req, input logic we, input logic [31:0] a,
                         input logic [3:0] be, input logic [31:0] wd);
    cpu_req = req; cpu_we = we; cpu_addr = a; cpu_byteen = be; cpu_wdata = wd;
  endtask

  task automatic set_dbg(input logic req, input logic we, input logic [31:0] a,
                         input logic [3:0] be, input logic [31:0] wd);
    dbg_req = req; dbg_we = we; dbg_addr = a; dbg_byteen = be; dbg_wdata = wd;
  endtask

  task automatic idle();
    set_cpu(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    set_dbg(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_cpu_gnt"},    cpu_gnt,    0);
    check_eq({tag, "_dbg_gnt"},    dbg_gnt,    0);
    check_eq({tag, "_cpu_rvalid"}, cpu_rvalid, 0);
    check_eq({tag, "_dbg_rvalid"}, dbg_rvalid, 0);
    check_eq({tag, "_cpu_rdata"},  cpu_rdata,  0);
    check_eq({tag, "_dbg_rdata"},  dbg_rdata,  0);
    check_eq({tag, "_dm_en"},      dm_en,      0);
    check_eq({tag, "_dm_byteen"},  dm_byteen,  0);
    check_eq({tag, "_dm_addr"},    dm_addr,    0);
    check_eq({tag, "_dm_wdata"},   dm_wdata,   0);
  endtask

  initial begin
    addr_mode = 1'b0;
    idle();
    reset = 1'b1;
    // Requests during reset must not be granted
    set_cpu(1'b1, 1'b0, 32'h14, 4'h0, 32'h0);
    set_dbg(1'b1, 1'b0, 32'h18, 4'h0, 32'h0);
    tick(); tick(); #1;
    check_all_zero("in_reset");
    tick(); reset = 1'b0; idle(); #1;
    check_all_zero("after_reset");

    // CPU-only store then load of the same word
    tick(); set_cpu(1'b1, 1'b1, 32'h0000_0014, 4'b1100, 32'h1234_0000); #1;
    check_eq("st_cpu_gnt", cpu_gnt, 1);
    check_eq("st_dbg_gnt", dbg_gnt, 0);
    check_eq("st_dm_en", dm_en, 1);
    check_eq("st_dm_addr", dm_addr, 5);
    check_eq("st_dm_byteen", dm_byteen, 4'b1100);
    check_eq("st_dm_wdata", dm_wdata, 32'h1234_0000);
    tick(); set_cpu(1'b1, 1'b0, 32'h0000_0014, 4'h0, 32'h0); #1;
    check_eq("ld_cpu_gnt", cpu_gnt, 1);
    check_eq("ld_dm_en", dm_en, 1);
    check_eq("ld_dm_byteen", dm_byteen, 0);
    tick(); idle(); #1;
    check_eq("ld_lat1_rvalid", cpu_rvalid, 0);
    tick(); #1;
    check_eq("ld_lat2_rvalid", cpu_rvalid, 0);
    tick(); #1;
    check_eq("ld_lat3_rvalid", cpu_rvalid, 1);
    check_eq("ld_lat3_rdata", cpu_rdata, 32'h1234_0000);
    check_eq("ld_lat3_dbg_rvalid", dbg_rvalid, 0);
    check_eq("ld_lat3_dbg_rdata", dbg_rdata, 0);

    // Contention right after reset: CPU, DBG, CPU, DBG, CPU, DBG
    tick(); reset = 1'b1;
    tick(); reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_cpu(1'b1, 1'b1, 32'h20, 4'h0, 32'hFFFF_FFFF);
      set_dbg(1'b1, 1'b1, 32'h24, 4'h0, 32'hFFFF_FFFF);
      #1;
      check_eq($sformatf("cont%0d_cpu_gnt", i), cpu_gnt, (i % 2 == 0) ? 1 : 0);
      check_eq($sformatf("cont%0d_dbg_gnt", i), dbg_gnt, (i % 2 == 0) ? 0 : 1);
      check_eq($sformatf("cont%0d_one_gnt", i), cpu_gnt & dbg_gnt, 0);
      tick();
    end

    // Interleaved loads, DM returns the word address as data
    idle(); addr_mode = 1'b1;
    set_cpu(1'b1, 1'b0, 32'h00, 4'h0, 32'h0); #1;
    check_eq("il0_cpu_gnt", cpu_gnt, 1);
    check_eq("il0_dm_addr", dm_addr, 0);
    tick(); cpu_req = 1'b0; set_dbg(1'b1, 1'b0, 32'h04, 4'h0, 32'h0); #1;
    check_eq("il1_dbg_gnt", dbg_gnt, 1);
    check_eq("il1_dm_addr", dm_addr, 1);
    tick(); dbg_req = 1'b0; set_cpu(1'b1, 1'b0, 32'h08, 4'h0, 32'h0); #1;
    check_eq("il2_cpu_gnt", cpu_gnt, 1);
    check_eq("il2_dm_addr", dm_addr, 2);
    // Cycle 3: first return alongside a zero-byteen debug store
    tick(); cpu_req = 1'b0; set_dbg(1'b1, 1'b1, 32'h14, 4'h0, 32'hFFFF_FFFF); #1;
    check_eq("il3_cpu_rvalid", cpu_rvalid, 1);
    check_eq("il3_cpu_rdata", cpu_rdata, 0);
    check_eq("il3_dbg_rvalid", dbg_rvalid, 0);
    check_eq("zb_dbg_gnt", dbg_gnt, 1);
    check_eq("zb_dm_en", dm_en, 1);
    check_eq("zb_dm_byteen", dm_byteen, 0);
    check_eq("zb_dm_addr", dm_addr, 5);
    tick(); idle(); #1;
    check_eq("il4_dbg_rvalid", dbg_rvalid, 1);
    check_eq("il4_dbg_rdata", dbg_rdata, 1);
    check_eq("il4_cpu_rvalid", cpu_rvalid, 0);
    check_eq("il4_cpu_rdata", cpu_rdata, 0);
    tick(); #1;
    check_eq("il5_cpu_rvalid", cpu_rvalid, 1);
    check_eq("il5_cpu_rdata", cpu_rdata, 2);
    check_eq("il5_dbg_rvalid", dbg_rvalid, 0);
    tick(); #1;
    check_eq("zb_no_dbg_rvalid", dbg_rvalid, 0);
    check_eq("zb_no_cpu_rvalid", cpu_rvalid, 0);
    addr_mode = 1'b0;

    // High address bits ignored; the zero-byteen store left the word intact
    tick(); set_cpu(1'b1, 1'b0, 32'hABC0_0017, 4'h0, 32'h0); #1;
    check_eq("hi_cpu_gnt", cpu_gnt, 1);
    check_eq("hi_dm_addr", dm_addr, 5);
    tick(); idle(); tick(); tick(); #1;
    check_eq("hi_rvalid", cpu_rvalid, 1);
    check_eq("hi_rdata", cpu_rdata, 32'h1234_0000);

    // Reset with a load in flight (CPU was granted last)
    tick(); set_cpu(1'b1, 1'b0, 32'h14, 4'h0, 32'h0); #1;
    check_eq("mf_cpu_gnt", cpu_gnt, 1);
    tick(); reset = 1'b1; set_dbg(1'b1, 1'b0, 32'h18, 4'h0, 32'h0); #1;
    check_eq("mf_rst_cpu_gnt", cpu_gnt, 0);
    check_eq("mf_rst_dbg_gnt", dbg_gnt, 0);
    tick(); reset = 1'b0; idle(); #1;
    check_all_zero("mf_after");
    tick(); #1;
    check_eq("mf_lat3_cpu_rvalid", cpu_rvalid, 0);
    check_eq("mf_lat3_dbg_rvalid", dbg_rvalid, 0);
    tick();
    set_cpu(1'b1, 1'b0, 32'h14, 4'h0, 32'h0);
    set_dbg(1'b1, 1'b0, 32'h18, 4'h0, 32'h0); #1;
    check_eq("mf_tie_cpu_gnt", cpu_gnt, 1);
    check_eq("mf_tie_dbg_gnt", dbg_gnt, 0);
    tick(); idle(); #1;
    check_eq("mf_lat4_cpu_rvalid", cpu_rvalid, 0);

`ifdef DM_ARB_STATS_EN
    // Stats: 4 contention cycles then 2 CPU-only cycles
    tick(); reset = 1'b1;
    tick(); reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_cpu(1'b1, 1'b1, 32'h30, 4'h0, 32'h0);
      set_dbg(i < 4, 1'b1, 32'h34, 4'h0, 32'h0);
      tick();
    end
    idle(); #1;
    check_eq("st_cpu_gnt_cnt", cpu_gnt_cnt, 4);
    check_eq("st_dbg_gnt_cnt", dbg_gnt_cnt, 2);
    check_eq("st_conflict_cnt", conflict_cnt, 4);
`endif

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dm_port_arbiter.md
Name: dm_port_arbiter

Overview:
Two-requester arbiter and sequencer for the shared data memory. Requester 0 is the CPU MEM stage, which drives byte enables and lane-aligned write data already produced by the store byte-enable logic. Requester 1 is the debug/bridge port. The block issues at most one DM command per cycle, using round-robin priority. It tracks read data through a fixed-latency DM read pipeline and returns each read to the requester that issued it.

Parameters:
ADDR_W, 12, DM word-address width; dm_addr = req_addr[ADDR_W+1:2]
RD_LAT, 1, DM read latency in cycles, legal range 1..4

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
cpu_req  in  1  CPU request valid; held with fields stable until cpu_gnt
cpu_we  in  1  1 = store, 0 = load
cpu_addr  in  32  byte address; bits [1:0] ignored
cpu_byteen  in  4  byte enables for a store; lane-aligned
cpu_wdata  in  32  lane-aligned store data
cpu_gnt  out  1  request accepted this cycle
cpu_rvalid  out  1  load data valid
cpu_rdata  out  32  load data, full word
dbg_req, dbg_we, dbg_addr, dbg_byteen, dbg_wdata  in  1/1/32/4/32  same meaning as the cpu_* inputs
dbg_gnt, dbg_rvalid  out  1  same meaning as the cpu_* outputs
dbg_rdata  out  32  same meaning as cpu_rdata
dm_en  out  1  DM command valid
dm_byteen  out  4  DM write byte enables; 0 for a read
dm_addr  out  ADDR_W  DM word address
dm_wdata  out  32  DM write data
dm_rdata  in  32  DM read data, valid RD_LAT cycles after a read command

Behaviour:
- Grant and command issue
  - Grant is combinational in the cycle of acceptance. The DM command (dm_en, dm_byteen, dm_addr, dm_wdata) is driven in that same cycle from the granted requester's fields.
  - With no grant: dm_en=0, dm_byteen=0, dm_addr=0, dm_wdata=0.
- Arbitration
  - Register last_gnt: 0 = CPU, 1 = debug. Reset value is 1, so the CPU wins the first tie.
  - Only one requester active: it is granted.
  - Both active: grant goes to the requester that is not last_gnt.
  - last_gnt updates only on a cycle with a grant.
  - At most one gnt is asserted per cycle.
- Stores
  - dm_byteen = granted byteen when we=1.
  - A store with byteen=0 is still granted and consumes the slot, but dm_byteen=0. No DM write occurs and no rvalid is produced.
  - Stores never produce rvalid.
- Loads
  - dm_byteen=0, dm_en=1.
  - A tag pipeline, RD_LAT stages deep, shifts a {valid, owner} pair every cycle.
  - Exactly RD_LAT cycles after a load is granted, the owner's rvalid=1 and its rdata = dm_rdata.
  - The non-owner's rvalid=0 and its rdata=0.
- Throughput: back-to-back loads, from either requester or interleaved, return one per cycle, in issue order.
- Holding: an ungranted requester keeps req high. Its request must not change fields while waiting, and the arbiter does not latch them.
- Request drop: if req is dropped before a grant, the request is simply not served. No error is flagged.
- Address: byte-address bits [1:0] are ignored, and bits above ADDR_W+1 are ignored.
- Reset (sync, active-high)
  - Tag pipeline cleared, last_gnt=1.
  - All outputs 0 in the cycle after reset is sampled high: gnt=0, rvalid=0, rdata=0, dm_en=0, dm_byteen=0, dm_addr=0, dm_wdata=0.
  - While reset=1, no grant is issued even if req=1.
  - Loads in flight when reset is asserted mid-operation are discarded; their rvalid never appears.
- Simultaneous events
  - A new grant and a returning rvalid in the same cycle are independent and both occur.
  - rvalid and gnt may both be asserted to the same requester in one cycle.

Optional Feature:
Macro DM_ARB_STATS_EN.
- Defined
  - Adds outputs cpu_gnt_cnt[15:0], dbg_gnt_cnt[15:0] and conflict_cnt[15:0].
  - cpu_gnt_cnt and dbg_gnt_cnt increment on each grant to that requester.
  - conflict_cnt increments on every cycle with both req=1.
  - All three saturate at 16'hFFFF and clear on reset.
- Undefined: the ports and counters are absent, and the arbitration behaviour is identical.

Test Plan:
- CPU-only traffic
  - Stimulus: cpu_req=1, we=1, addr=32'h0000_0014, byteen=4'b1100, wdata=32'h1234_0000.
  - Required: same cycle cpu_gnt=1, dm_addr=5, dm_byteen=4'b1100, dm_wdata=32'h1234_0000.
  - Then a load from the same address with the DM model returning 32'h1234_0000 -> cpu_rvalid=1 exactly RD_LAT cycles after the grant, with cpu_rdata=32'h1234_0000.
- Contention
  - Stimulus: both req held high for 6 cycles after reset.
  - Required grant order: CPU, DBG, CPU, DBG, CPU, DBG. Never both gnt in one cycle.
- Interleaved loads
  - Setup: RD_LAT=3; load CPU@0x00, then DBG@0x04, then CPU@0x08 in consecutive cycles; DM model returns the word address as data.
  - Required: cpu_rvalid with data 0 in cycle 3, dbg_rvalid with data 1 in cycle 4, cpu_rvalid with data 2 in cycle 5.
- Zero-byteen store
  - Stimulus: dbg_req, we=1, byteen=0.
  - Required: dbg_gnt=1, dm_en=1, dm_byteen=0, memory unchanged, no rvalid.
- Reset mid-flight
  - Stimulus: issue a load, then assert reset on the next cycle.
  - Required: no rvalid ever; all outputs 0 after the reset cycle; the first tie after reset is granted to the CPU.
- Stats counters (DM_ARB_STATS_EN defined)
  - Stimulus: 4 contention cycles, then 2 CPU-only cycles.
  - Required: cpu_gnt_cnt=4, dbg_gnt_cnt=2, conflict_cnt=4.
